// File: rtl/srl_fifo_rd.sv
`timescale 1ns/1ps
// Purpose : read-side drain for an SRL delay line; a ce-driven write stream is
//           captured in a reset-free shift array and presented oldest-first
//           through a registered valid/ready output stage.
// Latency : one cycle from an accepted write into an empty stage to dout_valid;
//           sustains one word per cycle while dout_ready stays high.
// Backpressure: while dout_valid && !dout_ready, dout/dout_valid hold and writes
//           keep filling the shift array; once it is full, ce drops the word and
//           sets the sticky overflow flag.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   ce, din         write strobe and data (accepted when ce && !full)
//   full            shift array holds DEPTH words
//   dout_valid/dout/dout_ready  registered output handshake
//   level           words held, shift array plus output register
//   overflow        sticky: a write was attempted while full
module srl_fifo_rd #(
    parameter int DATA_WIDTH = 16,
    parameter int DW         = DATA_WIDTH * 2,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW+1:0] level,
    output logic          overflow
);

    // Shift array: newest word at mem[0], oldest at mem[count-1].
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;

    logic          wr;
    logic          load;
    logic          have_stored;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_dat;

    assign full        = (count == (AW+1)'(DEPTH));
    assign wr          = ce && !full;
    assign have_stored = (count != '0);

    // Oldest word is read from the pre-shift array; the index is only
    // meaningful when have_stored is true.
    assign rd_idx = AW'(count - (AW+1)'(1));
    assign rd_dat = mem[rd_idx];

    // The output register may take a new word when it is empty or being
    // consumed this cycle, and there is a source: a stored word or a
    // write arriving into an empty array (bypass).
    assign load = (have_stored || wr) && (!dout_valid || dout_ready);

    // No reset and no parallel load so the array maps onto shift-register
    // primitives.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // A write that coincides with a load leaves count unchanged: either the
    // written word enters while the oldest leaves, or it bypasses the array.
    // A load without a write can only come from a stored word.
    always_comb begin
        count_nxt = count;
        if (wr && !load) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!wr && load) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (load) begin
                dout       <= have_stored ? rd_dat : din;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                // Consumed with nothing behind it; dout keeps its last value.
                dout_valid <= 1'b0;
            end
            if (ce && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign level = {1'b0, count} + (AW+2)'(dout_valid);

endmodule

// File: tb/tb_srl_fifo_rd.sv
`timescale 1ns/1ps
module tb_srl_fifo_rd;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [DW-1:0] din;
    logic          full;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [AW+1:0] level;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: the whole FIFO contents (output register included)
    // as one queue, head = word presented on dout.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;

    srl_fifo_rd #(.DATA_WIDTH(16), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .full       (full),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
    endfunction

    // Drive one clock of stimulus and advance the model. Returns at posedge+1.
    task automatic cycle(input logic c, input logic [DW-1:0] d, input logic r);
        bit m_full, pop, w;
        ce = c; din = d; dout_ready = r;
        m_full = (mq.size() == DEPTH + 1);
        pop    = (mq.size() > 0) && r;
        w      = c && !m_full;
        if (c && m_full) m_ovf = 1'b1;
        @(posedge clk); #1;
        if (pop) void'(mq.pop_front());
        if (w) mq.push_back(d);
        if (mq.size() > 0) m_dout = mq[0];
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; din = '0; dout_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; din = '0; dout_ready = 1'b0;
        #2;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", dout_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%0b ovf=%0b expected 0 0", full, overflow); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 34; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            checks++; if (level !== (AW+2)'(mq.size())) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, mq.size()); end
            if (i == 1) begin
                checks++; if (dout_valid !== 1'b1 || dout !== 32'd1) begin errors++; $display("FAIL fill_first: got valid=%0b dout=%0d expected 1 1", dout_valid, dout); end
            end
            if (i == 32) begin
                checks++; if (level !== 7'd32 || full !== 1'b0 || dout_valid !== 1'b1) begin errors++; $display("FAIL fill_32: got level=%0d full=%0b valid=%0b expected 32 0 1", level, full, dout_valid); end
            end
            if (i == 33) begin
                checks++; if (full !== 1'b1 || level !== 7'd33) begin errors++; $display("FAIL fill_33: got full=%0b level=%0d expected 1 33", full, level); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_33_ovf: got %0b expected 0", overflow); end
            end
            if (i == 34) begin
                checks++; if (overflow !== 1'b1 || level !== 7'd33 || full !== 1'b1) begin errors++; $display("FAIL fill_34: got ovf=%0b level=%0d full=%0b expected 1 33 1", overflow, level, full); end
            end
        end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 33; k++) begin
            checks++; if (dout_valid !== 1'b1 || dout !== DW'(k)) begin errors++; $display("FAIL drain_seq[%0d]: got valid=%0b dout=%0d expected 1 %0d", k, dout_valid, dout, k); end
            cycle(1'b0, '0, 1'b1);
        end
        checks++; if (dout_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL drain_empty: got valid=%0b level=%0d expected 0 0", dout_valid, level); end
        checks++; if (dout !== 32'd33) begin errors++; $display("FAIL drain_hold: got %0d expected 33", dout); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky: got %0b expected 1", overflow); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b0 || dout !== 32'd33) begin errors++; $display("FAIL drain_idle_ready: got valid=%0b dout=%0d expected 0 33", dout_valid, dout); end
    endtask

    task automatic test_bypass();
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b1, DW'(i), 1'b1);
            checks++; if (dout_valid !== 1'b1 || dout !== DW'(i) || level !== 7'd1 || full !== 1'b0) begin
                errors++; $display("FAIL bypass[%0d]: got valid=%0b dout=%0d level=%0d full=%0b expected 1 %0d 1 0", i, dout_valid, dout, level, full, i);
            end
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (dout_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL bypass_end: got valid=%0b level=%0d expected 0 0", dout_valid, level); end
    endtask

    task automatic test_backpressure();
        int            exp_next = 1;
        int            max_lvl  = 0;
        logic [DW-1:0] hold_d;
        logic          hold_v;
        logic          r;
        for (int i = 1; i <= 60; i++) begin
            if (i > 20 && mq.size() == 0) break;
            r = logic'(i % 2);
            hold_d = dout; hold_v = dout_valid;
            if (dout_valid && r) begin
                checks++; if (dout !== DW'(exp_next)) begin errors++; $display("FAIL bp_order: got %0d expected %0d", dout, exp_next); end
                exp_next++;
            end
            if (i <= 20) cycle(1'b1, DW'(i), r);
            else         cycle(1'b0, '0, r);
            if (!r) begin
                checks++; if (dout !== hold_d || dout_valid !== hold_v) begin errors++; $display("FAIL bp_stable[%0d]: got dout=%0d valid=%0b expected %0d %0b", i, dout, dout_valid, hold_d, hold_v); end
            end
            checks++; if (level !== (AW+2)'(mq.size())) begin errors++; $display("FAIL bp_level[%0d]: got %0d expected %0d", i, level, mq.size()); end
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        checks++; if (exp_next != 21) begin errors++; $display("FAIL bp_count: got %0d words expected 20", exp_next - 1); end
        checks++; if (max_lvl > 11) begin errors++; $display("FAIL bp_max_level: got %0d expected <= 11", max_lvl); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp [5];
        exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd99};
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0);
        checks++; if (dout !== 32'd1 || level !== 7'd5) begin errors++; $display("FAIL simul_pre: got dout=%0d level=%0d expected 1 5", dout, level); end
        cycle(1'b1, 32'd99, 1'b1);
        checks++; if (dout !== 32'd2 || level !== 7'd5 || dout_valid !== 1'b1) begin errors++; $display("FAIL simul_post: got dout=%0d level=%0d valid=%0b expected 2 5 1", dout, level, dout_valid); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (dout_valid !== 1'b1 || dout !== exp[k]) begin errors++; $display("FAIL simul_drain[%0d]: got valid=%0b dout=%0d expected 1 %0d", k, dout_valid, dout, exp[k]); end
            cycle(1'b0, '0, 1'b1);
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %0b expected 0", dout_valid); end
    endtask

    task automatic test_random();
        logic c, r;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            c = ($urandom_range(0, 9) < 7);
            r = (i < 250) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
            cycle(c, DW'($urandom), r);
            checks++; if (dout_valid !== (mq.size() > 0) || dout !== m_dout || level !== (AW+2)'(mq.size())
                         || full !== (mq.size() == DEPTH + 1) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random[%0d]: got valid=%0b dout=%0h level=%0d full=%0b ovf=%0b expected %0b %0h %0d %0b %0b",
                         i, dout_valid, dout, level, full, overflow, (mq.size() > 0), m_dout, mq.size(), (mq.size() == DEPTH + 1), m_ovf);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40 && mq.size() > 0; k++) cycle(1'b0, '0, 1'b1);
        for (int i = 1; i <= 10; i++) cycle(1'b1, DW'(100 + i), 1'b0);
        checks++; if (level !== 7'd10) begin errors++; $display("FAIL rmid_pre: got level=%0d expected 10", level); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dout_valid !== 1'b0 || dout !== '0 || level !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rmid_async: got valid=%0b dout=%0d level=%0d ovf=%0b expected 0 0 0 0", dout_valid, dout, level, overflow);
        end
        #2 rst = 1'b0;
        model_clear();
        cycle(1'b1, 32'd7, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 32'd7 || level !== 7'd1) begin errors++; $display("FAIL rmid_after: got valid=%0b dout=%0d level=%0d expected 1 7 1", dout_valid, dout, level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_bypass();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srl_fifo_rd.md
Name: srl_fifo_rd

Overview:
- Read-side companion to the `srl` shift-register delay line.
- Captures a ce-driven write stream into an SRL-inferable shift array.
- Presents the data to a downstream PE or consumer in arrival order, through a registered valid/ready output stage.
- Gives the PE array a backpressure-tolerant drain point for SRL-buffered operand streams.

Parameters:
- DW, `DATA_WIDTH*2, data word width (32 with DATA_WIDTH=16); matches `srl` din/dout.
- DEPTH, 32, number of shift-array entries. Power of two, 2..64. Total capacity is DEPTH+1 words, including the output register.
- AW, 5, log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  write strobe; din is accepted on a rising edge when ce=1 and full=0.
- din  in  DW  write data.
- full  out  1  high when count==DEPTH (combinational from count).
- dout  out  DW  oldest word; registered.
- dout_valid  out  1  dout holds a valid word; registered.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready.
- level  out  AW+2  words held = count + dout_valid.
- overflow  out  1  sticky; set when ce=1 while full=1.

Behaviour:
- Storage
  - mem[0..DEPTH-1], no reset.
  - On an accepted write: mem[0]<=din and mem[i]<=mem[i-1].
  - Must infer as SRL: no reset and no parallel load on mem.
- count (internal)
  - Width AW+1, range 0..DEPTH.
  - The oldest stored word is mem[count-1], using a combinational read of the pre-shift array.
- Load condition: load = (count>0 || wr) && (!dout_valid || dout_ready), where wr = ce && !full.
- Load source
  - count>0: dout<=mem[count-1].
  - count==0 and wr: bypass, dout<=din.
  - In both cases dout_valid<=1.
- count update
  - wr && load && count>0: unchanged.
  - wr && load && count==0: unchanged, 0 (bypass).
  - wr only: +1.
  - load only (count>0): -1.
  - neither: unchanged.
- dout_valid clear: when dout_valid && dout_ready && no load source exists, dout_valid<=0. dout holds its last value.
- Latency
  - Write at edge N with an empty stage gives dout_valid=1 and dout=din after edge N.
  - Continuous ce with dout_ready=1 gives throughput of one word per cycle.
- Backpressure: while dout_valid && !dout_ready, dout and dout_valid are stable and writes keep filling mem.
- Full
  - ce while full: write dropped, count unchanged, overflow<=1.
  - If a pop occurs in the same cycle, full is still evaluated pre-edge, so the write is dropped.
- Empty: dout_ready with dout_valid=0 has no effect.
- Reset (asynchronous assert, any time including mid-stream)
  - count=0, dout_valid=0, dout=0, overflow=0.
  - Stored words are discarded logically; mem contents are don't-care.
- Order: strict FIFO. No duplication and no loss except overflow drops.

Test Plan:
1. Fill to full
   - Stimulus: rst then release; dout_ready=0; ce=1 with din=1..32 on consecutive cycles.
   - Required: one cycle after the first write, dout_valid=1 and dout=1.
   - After 32 writes: level=32, count=31, full=0.
   - Write 33: full=1.
   - Write 34: dropped, overflow=1.
2. Drain
   - Stimulus: from state 1, ce=0, dout_ready=1.
   - Required: dout sequence 1,2,...,33 on consecutive cycles; then dout_valid=0 and level=0.
   - overflow remains 1 until rst.
3. Streaming bypass
   - Stimulus: dout_ready=1; ce=1 with din=1..32 every cycle.
   - Required: dout equals din delayed by one cycle; count stays 0; full never asserts.
4. Backpressure toggle
   - Stimulus: stream din=1..20; dout_ready alternates 1/0 each cycle.
   - Required: dout/dout_valid unchanged on every ready=0 cycle.
   - Consumed sequence is exactly 1..20; level never exceeds 11.
5. Simultaneous write and pop at count>0
   - Stimulus: preload 5 words (dout=1, count=4); one cycle with ce=1, din=99, dout_ready=1.
   - Required: dout=2, count stays 4, level stays 5.
   - Subsequent drain yields 2,3,4,5,99.
6. Reset mid-operation
   - Stimulus: level=10; assert rst for 3 ns between clock edges.
   - Required: dout_valid=0, dout=0, level=0, overflow=0 immediately.
   - Next write of din=7 gives dout=7 one cycle later.
